square_wave_meter: RTL and testbench
====================================

Name: square_wave_meter

Overview:
- Receive-side counterpart of the DA square-wave generator. Samples a 14-bit converter bus on edges of its externally supplied sample clock and slices it against a threshold into a logic level.
- Measures every half-period and the peak amplitude of each high half, and delimits bursts separated by idle gaps.
- Sits after the AD front end on the loopback/test board. Results go to the host as measurement records with a one-cycle valid strobe.

Parameters:
- Min_Stable, 2: consecutive samples of a new level needed before a transition is accepted (debounce).
- Idle_Timeout, 65535: samples with no accepted transition after which a burst ends.
- Count_Width, 32: width of the half-period and idle counters.
- Burst_Count_Width, 16: width of the period-per-burst counter.

Ports:
- Sys_Clock  input  1  system clock (108 MHz); all logic on its negative edge, matching the generator.
- nReset  input  1  asynchronous, active-low reset.
- AD_Clock  input  1  converter sample clock, asynchronous to Sys_Clock; treated as data.
- AD_Data  input  14  converter sample, stable around the AD_Clock rising edge.
- Threshold  input  14  slicing level; a sample is high when AD_Data >= Threshold (unsigned).
- Half_Period  output  Count_Width  length of the last completed half-period, in AD_Clock samples.
- Meas_Level  output  1  level of the half-period reported in Half_Period.
- Amplitude  output  14  maximum AD_Data seen during the reported half; 0 for low halves.
- Meas_Valid  output  1  one-cycle strobe; Half_Period, Meas_Level and Amplitude are new this cycle.
- Burst_Active  output  1  high while a burst is in progress.
- Burst_Count  output  Burst_Count_Width  full periods (accepted rising transitions) in the last completed burst.
- Burst_Done  output  1  one-cycle strobe when a burst ends; Burst_Count is updated in the same cycle.
- Overflow  output  1  sticky flag: a counter saturated. Cleared only by reset.

Behaviour:
- Reset: all outputs 0; state IDLE; accepted level low; all counters 0. Reset is legal at any time and discards any partial burst without a Burst_Done strobe.
- Sampling:
  - AD_Clock passes through a 2-flop synchronizer plus an edge register.
  - A synchronized rising edge produces a sample strobe; AD_Data is captured on that strobe.
  - AD_Data is assumed stable at least 3 Sys_Clock cycles after the AD_Clock edge.
  - Fixed latency: 3 Sys_Clock cycles from the AD_Clock edge to the registered sample.
- Slicing/debounce:
  - raw = (sample >= Threshold).
  - A run counter counts consecutive samples whose raw value differs from the accepted level; it resets to 0 when raw equals the accepted level.
  - When the run reaches Min_Stable, the transition is accepted and the accepted level toggles.
  - Shorter runs are glitches: ignored, but still counted into the current half-period.
- Half-period counter:
  - Increments on every sample strobe and saturates at all-ones, setting Overflow.
  - On an accepted transition it is reported, then restarts at Min_Stable, because the new half began Min_Stable samples earlier.
  - Reported count = sample strobes from the previous accepted transition to this one, measured identically at both ends.
- Amplitude tracker:
  - Running max of samples while the accepted level is high.
  - Cleared together with the half-period counter.
  - Glitch samples are included.
- Meas_Valid:
  - Pulses one Sys_Clock cycle after an accepted transition.
  - Suppressed for the first accepted transition of a burst, since its start is unknown.
  - Outputs hold their value between strobes.
- State machine:
  - IDLE: Burst_Active=0. An accepted low->high transition moves to BURST and sets the internal period count to 1. An accepted high->low transition in IDLE (signal stuck high at reset) stays in IDLE and emits no Meas_Valid.
  - BURST: Burst_Active=1. Each accepted low->high increments the period count, saturating and setting Overflow. The idle counter counts samples since the last accepted transition.
  - BURST->IDLE when the idle counter exceeds Idle_Timeout: Burst_Count takes the period count, Burst_Done pulses, and Meas_Valid is not asserted for the aborted half.
- Simultaneous events:
  - A timeout and an accepted transition on the same sample: the transition wins and the idle counter clears.
  - Burst_Done and Meas_Valid never assert in the same cycle.
- AD_Clock stopped: no strobes, so no counting; the block freezes in its current state.

Decomposition:
- Shared package square_wave_pkg: the Min_Stable/Idle_Timeout/width defaults and the IDLE/BURST state encoding. The generator uses the same package for its DA-width constant (14).
- One natural sub-module: ad_clock_sync, holding the 2-flop synchronizer, edge detect and the AD_Data capture register, which outputs sample_strobe and sample.

Test Plan:
1. Reset/idle: AD_Clock toggling every 3 Sys_Clock cycles, AD_Data=0, Threshold=1 -> all outputs remain 0; no strobes.
2. Steady wave: AD_Data alternating between 0 for 20 samples and 40 for 20 samples, Threshold=1:
   - first Meas_Valid appears at the second accepted transition;
   - then Half_Period=20 on every strobe, alternating Meas_Level;
   - Amplitude=40 for high halves and 0 for low halves.
3. Glitch: a single 1-sample zero inside a 20-sample high half, Min_Stable=2 -> no extra strobes; Half_Period still 20.
4. Burst end: 5 full periods, then AD_Data=0 with Idle_Timeout=100 -> Burst_Done pulses once on the 101st idle sample; Burst_Count=5; Burst_Active falls in the same cycle.
5. Saturation: Count_Width=8, high level held 300 samples -> Overflow=1; Half_Period=255 at the next transition.
6. Mid-burst reset: assert nReset during a high half -> outputs 0 immediately, no Burst_Done; the next burst reports a correct Burst_Count.

Source files
------------

// File: rtl/square_wave_pkg.sv
// Shared constants and state encoding for the square-wave generator/meter pair.
package square_wave_pkg;

    localparam int unsigned DA_WIDTH              = 14;
    localparam int unsigned MIN_STABLE_DEF        = 2;
    localparam int unsigned IDLE_TIMEOUT_DEF      = 65535;
    localparam int unsigned COUNT_WIDTH_DEF       = 32;
    localparam int unsigned BURST_COUNT_WIDTH_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } meter_state_t;

endpackage

// File: rtl/ad_clock_sync.sv
// Brings the converter sample clock into the Sys_Clock domain and captures
// AD_Data on each synchronized rising edge (3 cycles after the AD_Clock edge).
module ad_clock_sync
    import square_wave_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ad_clock_i,
    input  logic [DA_WIDTH-1:0] ad_data_i,
    output logic                sample_strobe_o,
    output logic [DA_WIDTH-1:0] sample_o
);

    logic                sync1_q;
    logic                sync2_q;
    logic                edge_q;
    logic                strobe_q;
    logic [DA_WIDTH-1:0] sample_q;
    logic                rise;

    assign rise = sync2_q & ~edge_q;

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            strobe_q <= 1'b0;
            sample_q <= '0;
        end else begin
            sync1_q  <= ad_clock_i;
            sync2_q  <= sync1_q;
            edge_q   <= sync2_q;
            strobe_q <= rise;
            if (rise) begin
                sample_q <= ad_data_i;
            end
        end
    end

    assign sample_strobe_o = strobe_q;
    assign sample_o        = sample_q;

endmodule

// File: rtl/square_wave_meter.sv
// Slices converter samples against a threshold, debounces the level, and
// reports half-periods, high-half peak amplitude and per-burst period counts.
module square_wave_meter
    import square_wave_pkg::*;
#(
    parameter int unsigned Min_Stable        = MIN_STABLE_DEF,
    parameter int unsigned Idle_Timeout      = IDLE_TIMEOUT_DEF,
    parameter int unsigned Count_Width       = COUNT_WIDTH_DEF,
    parameter int unsigned Burst_Count_Width = BURST_COUNT_WIDTH_DEF
) (
    input  logic                         Sys_Clock,
    input  logic                         nReset,
    input  logic                         AD_Clock,
    input  logic [DA_WIDTH-1:0]          AD_Data,
    input  logic [DA_WIDTH-1:0]          Threshold,
    output logic [Count_Width-1:0]       Half_Period,
    output logic                         Meas_Level,
    output logic [DA_WIDTH-1:0]          Amplitude,
    output logic                         Meas_Valid,
    output logic                         Burst_Active,
    output logic [Burst_Count_Width-1:0] Burst_Count,
    output logic                         Burst_Done,
    output logic                         Overflow
);

    localparam int unsigned CW    = Count_Width;
    localparam int unsigned BW    = Burst_Count_Width;
    localparam int unsigned RUN_W = $clog2(Min_Stable + 1);
    localparam int unsigned EXT_W = CW + 32;

    localparam logic [CW-1:0]    CNT_MAX  = '1;
    localparam logic [BW-1:0]    PER_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(Min_Stable - 1);

    logic                sample_strobe;
    logic [DA_WIDTH-1:0] sample;

    ad_clock_sync u_sync (
        .clk_i           (Sys_Clock),
        .rst_ni          (nReset),
        .ad_clock_i      (AD_Clock),
        .ad_data_i       (AD_Data),
        .sample_strobe_o (sample_strobe),
        .sample_o        (sample)
    );

    meter_state_t        state_q, state_d;
    logic                acc_q, acc_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [DA_WIDTH-1:0] run_max_q, run_max_d;
    logic [CW-1:0]       hp_q, hp_d;
    logic [DA_WIDTH-1:0] amp_q, amp_d;
    logic [CW-1:0]       idle_q, idle_d;
    logic [BW-1:0]       per_q, per_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       hp_out_q, hp_out_d;
    logic                lvl_out_q, lvl_out_d;
    logic [DA_WIDTH-1:0] amp_out_q, amp_out_d;
    logic                valid_q, valid_d;
    logic [BW-1:0]       bcount_q, bcount_d;
    logic                bdone_q, bdone_d;

    logic                raw;
    logic                accept;
    logic [DA_WIDTH-1:0] run_max_upd;
    logic [EXT_W-1:0]    idle_ext;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        run_d     = run_q;
        run_max_d = run_max_q;
        hp_d      = hp_q;
        amp_d     = amp_q;
        idle_d    = idle_q;
        per_d     = per_q;
        ovf_d     = ovf_q;
        hp_out_d  = hp_out_q;
        lvl_out_d = lvl_out_q;
        amp_out_d = amp_out_q;
        bcount_d  = bcount_q;
        valid_d   = 1'b0;
        bdone_d   = 1'b0;
        accept    = 1'b0;
        idle_ext  = '0;

        raw         = (sample >= Threshold);
        run_max_upd = (run_q == '0 || sample > run_max_q) ? sample : run_max_q;

        if (sample_strobe) begin
            if (hp_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                hp_d = hp_q + 1'b1;
            end
            if (acc_q && sample > amp_q) begin
                amp_d = sample;
            end

            if (raw != acc_q) begin
                run_max_d = run_max_upd;
                if (run_q == RUN_LAST) begin
                    accept = 1'b1;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end else begin
                run_d     = '0;
                run_max_d = '0;
            end

            if (accept) begin
                // The new half started Min_Stable samples ago: restart the
                // counter there and seed the peak from the debounce run.
                acc_d     = raw;
                run_d     = '0;
                run_max_d = '0;
                hp_d      = CW'(Min_Stable);
                amp_d     = raw ? run_max_upd : '0;
                idle_d    = '0;
                if (state_q == BURST) begin
                    valid_d   = 1'b1;
                    hp_out_d  = (hp_q == CNT_MAX) ? CNT_MAX : hp_q - CW'(Min_Stable - 1);
                    lvl_out_d = acc_q;
                    amp_out_d = acc_q ? amp_q : '0;
                end
                if (raw) begin
                    if (state_q == IDLE) begin
                        state_d = BURST;
                        per_d   = BW'(1);
                    end else if (per_q == PER_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
            end else if (state_q == BURST) begin
                if (idle_q != CNT_MAX) begin
                    idle_d = idle_q + 1'b1;
                end
                idle_ext = EXT_W'(idle_d);
                if (idle_ext > EXT_W'(Idle_Timeout)) begin
                    state_d  = IDLE;
                    bcount_d = per_q;
                    bdone_d  = 1'b1;
                    idle_d   = '0;
                end
            end
        end
    end

    always_ff @(negedge Sys_Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            run_q     <= '0;
            run_max_q <= '0;
            hp_q      <= '0;
            amp_q     <= '0;
            idle_q    <= '0;
            per_q     <= '0;
            ovf_q     <= 1'b0;
            hp_out_q  <= '0;
            lvl_out_q <= 1'b0;
            amp_out_q <= '0;
            valid_q   <= 1'b0;
            bcount_q  <= '0;
            bdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            run_q     <= run_d;
            run_max_q <= run_max_d;
            hp_q      <= hp_d;
            amp_q     <= amp_d;
            idle_q    <= idle_d;
            per_q     <= per_d;
            ovf_q     <= ovf_d;
            hp_out_q  <= hp_out_d;
            lvl_out_q <= lvl_out_d;
            amp_out_q <= amp_out_d;
            valid_q   <= valid_d;
            bcount_q  <= bcount_d;
            bdone_q   <= bdone_d;
        end
    end

    assign Half_Period  = hp_out_q;
    assign Meas_Level   = lvl_out_q;
    assign Amplitude    = amp_out_q;
    assign Meas_Valid   = valid_q;
    assign Burst_Active = (state_q == BURST);
    assign Burst_Count  = bcount_q;
    assign Burst_Done   = bdone_q;
    assign Overflow     = ovf_q;

endmodule

// File: tb/tb_square_wave_meter.sv
// Scoreboard bench: stimulus pushes expected records, monitors pop them on strobes.
module tb_square_wave_meter;

    typedef struct {
        int unsigned hp;
        int unsigned lvl;
        int unsigned amp;
    } meas_t;

    logic        Sys_Clock;
    logic        nReset;
    logic        nReset_sat;
    logic        AD_Clock;
    logic [13:0] AD_Data;
    logic [13:0] AD_Data_sat;
    logic [13:0] Threshold;

    logic [31:0] Half_Period;
    logic        Meas_Level;
    logic [13:0] Amplitude;
    logic        Meas_Valid;
    logic        Burst_Active;
    logic [15:0] Burst_Count;
    logic        Burst_Done;
    logic        Overflow;

    logic [7:0]  s_Half_Period;
    logic        s_Meas_Level;
    logic [13:0] s_Amplitude;
    logic        s_Meas_Valid;
    logic        s_Burst_Active;
    logic [15:0] s_Burst_Count;
    logic        s_Burst_Done;
    logic        s_Overflow;

    int unsigned checks = 0;
    int unsigned errors = 0;

    meas_t       exp_m[$];
    meas_t       exp_ms[$];
    int unsigned exp_b[$];
    int unsigned exp_bs[$];

    square_wave_meter #(
        .Min_Stable(2), .Idle_Timeout(100), .Count_Width(32), .Burst_Count_Width(16)
    ) dut (
        .Sys_Clock(Sys_Clock), .nReset(nReset), .AD_Clock(AD_Clock),
        .AD_Data(AD_Data), .Threshold(Threshold),
        .Half_Period(Half_Period), .Meas_Level(Meas_Level), .Amplitude(Amplitude),
        .Meas_Valid(Meas_Valid), .Burst_Active(Burst_Active), .Burst_Count(Burst_Count),
        .Burst_Done(Burst_Done), .Overflow(Overflow)
    );

    square_wave_meter #(
        .Min_Stable(2), .Idle_Timeout(65535), .Count_Width(8), .Burst_Count_Width(16)
    ) dut_sat (
        .Sys_Clock(Sys_Clock), .nReset(nReset_sat), .AD_Clock(AD_Clock),
        .AD_Data(AD_Data_sat), .Threshold(Threshold),
        .Half_Period(s_Half_Period), .Meas_Level(s_Meas_Level), .Amplitude(s_Amplitude),
        .Meas_Valid(s_Meas_Valid), .Burst_Active(s_Burst_Active), .Burst_Count(s_Burst_Count),
        .Burst_Done(s_Burst_Done), .Overflow(s_Overflow)
    );

    initial begin
        Sys_Clock = 1'b0;
        forever #5 Sys_Clock = ~Sys_Clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_m(input int unsigned hp, input int unsigned lvl, input int unsigned amp);
        meas_t e;
        e.hp = hp; e.lvl = lvl; e.amp = amp;
        exp_m.push_back(e);
    endtask

    task automatic push_ms(input int unsigned hp, input int unsigned lvl, input int unsigned amp);
        meas_t e;
        e.hp = hp; e.lvl = lvl; e.amp = amp;
        exp_ms.push_back(e);
    endtask

    // One AD_Clock period: 3 Sys_Clock cycles high, 3 low, data held throughout.
    task automatic drive(input logic [13:0] v, input logic [13:0] vs);
        AD_Data     = v;
        AD_Data_sat = vs;
        AD_Clock    = 1'b1;
        repeat (3) @(posedge Sys_Clock);
        AD_Clock    = 1'b0;
        repeat (3) @(posedge Sys_Clock);
    endtask

    task automatic level(input logic [13:0] v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(v, 14'd0);
    endtask

    task automatic level_sat(input logic [13:0] vs, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(14'd0, vs);
    endtask

    always @(posedge Sys_Clock) begin
        meas_t e;
        if (Meas_Valid) begin
            check("overlap", Burst_Done, 0);
            if (exp_m.size() == 0) begin
                check("unexpected_valid", Meas_Valid, 0);
            end else begin
                e = exp_m.pop_front();
                check("half_period", Half_Period, e.hp);
                check("meas_level", Meas_Level, e.lvl);
                check("amplitude", Amplitude, e.amp);
            end
        end
        if (Burst_Done) begin
            if (exp_b.size() == 0) begin
                check("unexpected_done", Burst_Done, 0);
            end else begin
                check("burst_count", Burst_Count, exp_b.pop_front());
                check("active_at_done", Burst_Active, 0);
            end
        end
    end

    always @(posedge Sys_Clock) begin
        meas_t e;
        if (s_Meas_Valid) begin
            if (exp_ms.size() == 0) begin
                check("sat_unexpected_valid", s_Meas_Valid, 0);
            end else begin
                e = exp_ms.pop_front();
                check("sat_half_period", s_Half_Period, e.hp);
                check("sat_meas_level", s_Meas_Level, e.lvl);
                check("sat_amplitude", s_Amplitude, e.amp);
            end
        end
        if (s_Burst_Done) begin
            if (exp_bs.size() == 0) begin
                check("sat_unexpected_done", s_Burst_Done, 0);
            end else begin
                check("sat_burst_count", s_Burst_Count, exp_bs.pop_front());
            end
        end
    end

    initial begin
        Threshold   = 14'd1;
        nReset      = 1'b0;
        nReset_sat  = 1'b0;
        AD_Clock    = 1'b0;
        AD_Data     = '0;
        AD_Data_sat = '0;
        repeat (4) @(posedge Sys_Clock);
        check("rst_half_period", Half_Period, 0);
        check("rst_active", Burst_Active, 0);
        check("rst_valid", Meas_Valid, 0);
        check("rst_done", Burst_Done, 0);
        nReset = 1'b1;

        // Idle clocking with data below threshold
        level(14'd0, 30);
        check("idle_half_period", Half_Period, 0);
        check("idle_level", Meas_Level, 0);
        check("idle_amplitude", Amplitude, 0);
        check("idle_active", Burst_Active, 0);
        check("idle_count", Burst_Count, 0);
        check("idle_overflow", Overflow, 0);

        // Five periods with glitches, peak-at-run-start and threshold-equal samples
        push_m(20, 1, 40);    push_m(20, 0, 0);
        push_m(20, 1, 55);    push_m(20, 0, 0);
        push_m(20, 1, 1000);  push_m(20, 0, 0);
        push_m(20, 1, 16383); push_m(20, 0, 0);
        push_m(20, 1, 40);
        exp_b.push_back(5);
        level(14'd40, 20);
        check("burst_started", Burst_Active, 1);
        level(14'd0, 20);
        for (int unsigned i = 0; i < 20; i++) drive((i == 10) ? 14'd0 : 14'd55, 14'd0);
        for (int unsigned i = 0; i < 20; i++) drive((i == 5) ? 14'd7 : 14'd0, 14'd0);
        for (int unsigned i = 0; i < 20; i++) drive((i == 0) ? 14'd1000 : 14'd1, 14'd0);
        level(14'd0, 20);
        level(14'd16383, 20);
        level(14'd0, 20);
        level(14'd40, 20);
        level(14'd0, 102);
        check("active_before_timeout", Burst_Active, 1);
        check("no_early_done", exp_b.size(), 1);
        drive(14'd0, 14'd0);
        check("active_after_timeout", Burst_Active, 0);
        check("count_after_timeout", Burst_Count, 5);
        check("hold_half_period", Half_Period, 20);
        check("done_seen", exp_b.size(), 0);

        // Reset in the middle of a high half
        push_m(20, 1, 77); push_m(20, 0, 0);
        level(14'd0, 20);
        level(14'd77, 20);
        level(14'd0, 20);
        level(14'd77, 10);
        check("mid_active", Burst_Active, 1);
        nReset = 1'b0;
        #1;
        check("mrst_half_period", Half_Period, 0);
        check("mrst_amplitude", Amplitude, 0);
        check("mrst_active", Burst_Active, 0);
        check("mrst_count", Burst_Count, 0);
        check("mrst_meas_seen", exp_m.size(), 0);
        repeat (3) @(posedge Sys_Clock);
        nReset = 1'b1;
        push_m(20, 1, 90); push_m(20, 0, 0);
        push_m(20, 1, 90); push_m(20, 0, 0);
        push_m(20, 1, 90);
        exp_b.push_back(3);
        level(14'd0, 20);
        for (int unsigned k = 0; k < 3; k++) begin
            level(14'd90, 20);
            level(14'd0, 20);
        end
        level(14'd0, 110);
        check("rb_count", Burst_Count, 3);
        check("rb_active", Burst_Active, 0);

        // Saturation on the 8-bit instance
        nReset_sat = 1'b1;
        push_ms(255, 1, 500); push_ms(20, 0, 0);
        level_sat(14'd0, 20);
        level_sat(14'd500, 300);
        check("sat_overflow_set", s_Overflow, 1);
        check("sat_no_report_yet", s_Half_Period, 0);
        level_sat(14'd0, 20);
        level_sat(14'd500, 20);
        check("sat_overflow_sticky", s_Overflow, 1);
        check("sat_active", s_Burst_Active, 1);
        check("main_overflow", Overflow, 0);

        repeat (10) @(posedge Sys_Clock);
        check("meas_queue_empty", exp_m.size(), 0);
        check("burst_queue_empty", exp_b.size(), 0);
        check("sat_queue_empty", exp_ms.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
